// File: rtl/cache_refill_pkg.sv
// Shared constants, FSM state type and address-field helpers for the cache
// line refill engine and the tag lookup that feeds it.
package cache_refill_pkg;

  localparam int CR_TAG_W  = 22;
  localparam int CR_IDX_W  = 5;
  localparam int CR_WORDS  = 8;
  localparam int CR_WORD_W = $clog2(CR_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INVAL,
    ST_REQ,
    ST_FILL,
    ST_COMMIT
  } state_e;

  function automatic logic [CR_TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31 -: CR_TAG_W];
  endfunction

  function automatic logic [CR_IDX_W-1:0] addr_idx(input logic [31:0] addr);
    return addr[31-CR_TAG_W -: CR_IDX_W];
  endfunction

  function automatic logic [CR_WORD_W-1:0] addr_word(input logic [31:0] addr);
    return addr[2 +: CR_WORD_W];
  endfunction

endpackage

// File: rtl/cache_refill_ctr.sv
// Wrapping beat counter: remembers its load value so terminal count fires on
// the last beat of a burst regardless of where the burst started.
module cache_refill_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] start_q, start_d;

  always_comb begin
    cnt_d   = cnt_q;
    start_d = start_q;
    if (load) begin
      cnt_d   = load_val;
      start_d = load_val;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      start_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  assign cnt = cnt_q;
  // Last beat is the one whose successor would wrap back to the start word.
  assign tc  = ((cnt_q + W'(1)) == start_q);

endmodule

// File: rtl/cache_refill.sv
// Cache miss refill engine: invalidate, burst-read a line, commit its tag.
// Define CACHE_REFILL_CRIT_WORD_EN for critical-word-first bursts with forwarding.
module cache_refill
  import cache_refill_pkg::*;
#(
  parameter int TAG_W = CR_TAG_W,
  parameter int IDX_W = CR_IDX_W,
  parameter int WORDS = CR_WORDS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  input  logic                     lookup_hit,
  output logic                     stall,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic                     mem_rvalid,
  input  logic [31:0]              mem_rdata,
  output logic                     data_we,
  output logic [IDX_W-1:0]         data_idx,
  output logic [$clog2(WORDS)-1:0] data_word,
  output logic [31:0]              data_wdata,
  output logic                     tag_we,
  output logic                     tag_clr,
  output logic [IDX_W-1:0]         tag_idx,
  output logic [TAG_W-1:0]         tag_wdata,
  output logic                     cpu_rvalid,
  output logic [31:0]              cpu_rdata
);

  localparam int WORD_W = $clog2(WORDS);

`ifdef CACHE_REFILL_CRIT_WORD_EN
  localparam bit CRIT_EN = 1'b1;
`else
  localparam bit CRIT_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              ctr_load, ctr_inc, ctr_tc;
  logic [WORD_W-1:0] ctr_cnt;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[1:0];

  cache_refill_ctr #(.W(WORD_W)) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (word_d),
    .inc      (ctr_inc),
    .cnt      (ctr_cnt),
    .tc       (ctr_tc)
  );

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    word_d     = word_q;
    ctr_load   = 1'b0;
    ctr_inc    = 1'b0;
    stall      = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    data_we    = 1'b0;
    data_idx   = '0;
    data_word  = '0;
    data_wdata = '0;
    tag_we     = 1'b0;
    tag_clr    = 1'b0;
    tag_idx    = '0;
    tag_wdata  = '0;
    case (state_q)
      ST_IDLE: begin
        // Reset must also silence the combinational miss stall.
        if (req_valid && !lookup_hit && !rst) begin
          stall    = 1'b1;
          tag_d    = addr_tag(req_addr);
          idx_d    = addr_idx(req_addr);
          word_d   = CRIT_EN ? addr_word(req_addr) : '0;
          ctr_load = 1'b1;
          state_d  = ST_INVAL;
        end
      end
      ST_INVAL: begin
        stall   = 1'b1;
        tag_clr = 1'b1;
        tag_idx = idx_q;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {tag_q, idx_q, word_q, 2'b00};
        if (mem_ack) state_d = ST_FILL;
      end
      ST_FILL: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          data_we    = 1'b1;
          data_idx   = idx_q;
          data_word  = ctr_cnt;
          data_wdata = mem_rdata;
          ctr_inc    = 1'b1;
          if (ctr_tc) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        stall     = 1'b1;
        tag_we    = 1'b1;
        tag_idx   = idx_q;
        tag_wdata = tag_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tag_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

`ifdef CACHE_REFILL_CRIT_WORD_EN
  assign cpu_rvalid = (state_q == ST_FILL) && mem_rvalid && (ctr_cnt == word_q);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
`else
  assign cpu_rvalid = 1'b0;
  assign cpu_rdata  = '0;
`endif

endmodule

// File: tb/tb_cache_refill.sv
// Randomized bench for cache_refill: a memory/line model supplies bursts and
// every observed write is compared against what the miss address implies.
module tb_cache_refill;

`ifdef CACHE_REFILL_CRIT_WORD_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic        clk, rst;
  logic        req_valid, lookup_hit;
  logic [31:0] req_addr;
  logic        stall, mem_req, mem_ack, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic        data_we, tag_we, tag_clr, cpu_rvalid;
  logic [4:0]  data_idx, tag_idx;
  logic [2:0]  data_word;
  logic [31:0] data_wdata, cpu_rdata;
  logic [21:0] tag_wdata;

  cache_refill dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .lookup_hit(lookup_hit), .stall(stall), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .data_we(data_we), .data_idx(data_idx),
    .data_word(data_word), .data_wdata(data_wdata), .tag_we(tag_we),
    .tag_clr(tag_clr), .tag_idx(tag_idx), .tag_wdata(tag_wdata),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] line_mem [8];
  int          wr_word_q [$];
  int          wr_idx_q [$];
  logic [31:0] wr_data_q [$];
  int          clr_idx_q [$];
  int          tagw_idx_q [$];
  logic [31:0] tagw_q [$];
  logic [31:0] maddr_q [$];
  logic [31:0] cpu_q [$];
  int          stall_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_word_q.delete(); wr_idx_q.delete(); wr_data_q.delete();
    clr_idx_q.delete(); tagw_idx_q.delete(); tagw_q.delete();
    maddr_q.delete(); cpu_q.delete();
    stall_cnt = 0;
  endtask

  task automatic set_line(input bit seq);
    for (int i = 0; i < 8; i++) line_mem[i] = seq ? 32'(i) : $urandom;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic sample();
    #1;
    check("ctl_exclusive", 32'($countones({data_we, tag_we, tag_clr, mem_req}) <= 1), 32'd1);
    if (stall)      stall_cnt++;
    if (data_we)    begin wr_word_q.push_back(int'(data_word)); wr_idx_q.push_back(int'(data_idx)); wr_data_q.push_back(data_wdata); end
    if (tag_clr)    clr_idx_q.push_back(int'(tag_idx));
    if (tag_we)     begin tagw_idx_q.push_back(int'(tag_idx)); tagw_q.push_back(32'(tag_wdata)); end
    if (mem_req)    maddr_q.push_back(mem_addr);
    if (cpu_rvalid) cpu_q.push_back(cpu_rdata);
    @(negedge clk);
  endtask

  task automatic run_hit();
    req_valid = 1'b1; req_addr = $urandom; lookup_hit = 1'b1; mem_rvalid = 1'($urandom);
    #1;
    check("hit_quiet", {27'd0, stall, mem_req, data_we, tag_we, tag_clr}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; mem_rvalid = 1'b0;
    $display("hit   addr=0x%08h", req_addr);
  endtask

  task automatic run_miss(input logic [31:0] a, input int ack_dly, input int gap_max,
                          input bit stray, input int rst_beat, input string nm);
    int          start, gaps, w;
    logic [31:0] exp_maddr;
    start     = CRIT ? int'(a[4:2]) : 0;
    exp_maddr = CRIT ? {a[31:2], 2'b00} : {a[31:5], 5'b0};
    gaps      = 0;
    clear_logs();
    req_valid = 1'b1; req_addr = a; lookup_hit = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0;
    #1;
    check({nm, "_stall_comb"}, 32'(stall), 32'd1);
    @(negedge clk);
    // Refill in progress: CPU side and stray beats must be ignored.
    req_valid = 1'($urandom); req_addr = $urandom; lookup_hit = 1'($urandom);
    mem_rvalid = stray; mem_rdata = 32'hBAD0_0000;
    sample();
    check({nm, "_inval_first"}, 32'(clr_idx_q.size()), 32'd1);
    for (int k = 0; k <= ack_dly; k++) begin
      mem_ack = (k == ack_dly);
      mem_rvalid = stray && ((k == 0) || ($urandom_range(1, 0) == 1));
      mem_rdata = $urandom;
      sample();
    end
    mem_ack = 1'b0;
    for (int b = 0; b < 8; b++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin
        mem_rvalid = 1'b0; mem_rdata = $urandom; sample(); gaps++;
      end
      w = (start + b) % 8;
      mem_rvalid = 1'b1; mem_rdata = line_mem[w];
      if (b == rst_beat) begin
        rst = 1'b1;
        #1;
        check({nm, "_rst_ctl"}, {26'd0, stall, mem_req, data_we, tag_we, tag_clr, cpu_rvalid}, 32'd0);
        check({nm, "_rst_maddr"}, mem_addr, 32'd0);
        check({nm, "_rst_beats"}, 32'(wr_word_q.size()), 32'(b));
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0; mem_rvalid = 1'b0;
        #1;
        check({nm, "_rst_idle"}, {30'd0, stall, mem_req}, 32'd0);
        check({nm, "_rst_no_tagwe"}, 32'(tagw_q.size()), 32'd0);
        @(negedge clk);
        $display("miss  %s addr=0x%08h reset at beat %0d", nm, a, b + 1);
        return;
      end
      if (b == 7) req_valid = 1'b0;
      sample();
    end
    mem_rvalid = 1'b0; req_valid = 1'b0;
    sample();
    #1;
    check({nm, "_stall_drop"}, {30'd0, stall, mem_req}, 32'd0);
    check({nm, "_clr_idx"}, (clr_idx_q.size() > 0) ? 32'(clr_idx_q[0]) : 32'hFFFF_FFFF, 32'(a[9:5]));
    check({nm, "_maddr_len"}, 32'(maddr_q.size()), 32'(ack_dly + 1));
    foreach (maddr_q[i]) check({nm, "_maddr"}, maddr_q[i], exp_maddr);
    check({nm, "_beats"}, 32'(wr_word_q.size()), 32'd8);
    foreach (wr_word_q[i]) begin
      check({nm, "_word"}, 32'(wr_word_q[i]), 32'((start + i) % 8));
      check({nm, "_widx"}, 32'(wr_idx_q[i]), 32'(a[9:5]));
      check({nm, "_wdata"}, wr_data_q[i], line_mem[(start + i) % 8]);
    end
    check({nm, "_tagwe_cnt"}, 32'(tagw_q.size()), 32'd1);
    if (tagw_q.size() > 0) begin
      check({nm, "_tag"}, tagw_q[0], 32'(a[31:10]));
      check({nm, "_tag_idx"}, 32'(tagw_idx_q[0]), 32'(a[9:5]));
    end
    check({nm, "_stall_cycles"}, 32'(stall_cnt), 32'(11 + ack_dly + gaps));
    check({nm, "_cpu_cnt"}, 32'(cpu_q.size()), CRIT ? 32'd1 : 32'd0);
    if (CRIT && cpu_q.size() > 0) check({nm, "_cpu_data"}, cpu_q[0], line_mem[start]);
    $display("miss  %s addr=0x%08h ack_dly=%0d gaps=%0d stall=%0d", nm, a, ack_dly, gaps, stall_cnt);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b1; req_addr = 32'hFFFF_FFE0; lookup_hit = 1'b0;
    mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    clear_logs();
    @(negedge clk); @(negedge clk);
    #1;
    check("reset_ctl", {26'd0, stall, mem_req, data_we, tag_we, tag_clr, cpu_rvalid}, 32'd0);
    check("reset_maddr", mem_addr, 32'd0);
    check("reset_wdata", data_wdata | cpu_rdata | 32'(tag_wdata), 32'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);

    repeat (3) run_hit();
    set_line(1'b1); run_miss(32'hFFFF_FC20, 0, 0, 1'b0, -1, "miss_fc20");
    set_line(1'b0); run_miss(32'h0000_003C, 0, 0, 1'b0, -1, "miss_3c");
    set_line(1'b0); run_miss(32'h1234_5678, 5, 0, 1'b1, -1, "ack_dly5");
    set_line(1'b0); run_miss(32'hA5A5_A5A4, 1, 2, 1'b1, -1, "gaps");
    set_line(1'b0); run_miss($urandom, 0, 0, 1'b0, 3, "rst_beat4");
    set_line(1'b0); run_miss($urandom, 0, 0, 1'b0, -1, "after_rst");

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(3, 0) == 0) begin
        run_hit();
      end else begin
        set_line(1'b0);
        run_miss($urandom, int'($urandom_range(4, 0)), int'($urandom_range(2, 0)),
                 1'($urandom_range(1, 0)),
                 ($urandom_range(7, 0) == 0) ? int'($urandom_range(7, 0)) : -1, "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
